// File: rtl/i2c_byte_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_byte_sequencer
//
// Single-byte I2C master. Each accepted request runs one transaction:
//   START, {addr,rw} MSB first, address ACK, one data byte (write or read),
//   data ACK / master NACK, STOP.
// SCL is generated from a quarter-phase timer (DIVIDER clk per quarter) and
// the slave may stretch the high half of any SCL period.
// Pads are open-drain: the *_oe outputs pull the line low when 1.
//
// Ports
//   clk      system clock, rising edge
//   rst      asynchronous active-low reset
//   start    request pulse, accepted only while idle
//   addr     7-bit slave address (captured on accept)
//   rw       0 = write, 1 = read (captured on accept)
//   wdata    byte to write (captured on accept)
//   busy     transaction in progress
//   done     one-cycle pulse when the transaction finishes
//   ack_err  slave NACKed address or write data; held until next accept
//   rdata    byte read from the slave; held until next accept
//   scl_oe   1 = pull SCL low
//   sda_oe   1 = pull SDA low
//   scl_in   synchronised SCL pad level
//   sda_in   synchronised SDA pad level
// ---------------------------------------------------------------------------
module i2c_byte_sequencer #(
    parameter int DIVIDER = 4,
    parameter int CBITS   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rdata,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       scl_in,
    input  logic       sda_in
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_AACK,
        S_WRITE,
        S_WACK,
        S_READ,
        S_RNACK,
        S_STOP
    } state_t;

    localparam logic [CBITS-1:0] LP_CNT_MAX = CBITS'(DIVIDER - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CBITS-1:0] r_cnt;
    logic [1:0]       r_q;
    logic [2:0]       r_bit;
    logic [7:0]       r_abyte;      // {addr, rw}
    logic [7:0]       r_wdata;
    logic [7:0]       r_rdata;
    logic             r_ack_err;
    logic             r_sda_oe;
    logic             r_done;

    logic             w_scl_oe;
    logic             w_stretch;
    logic             w_adv;
    logic             w_q_end;
    logic             w_slot_end;
    logic             w_sample;
    logic             w_accept;
    logic             w_byte_last;
    logic             w_tx_bit;
    logic             w_sda_oe_next;

    // SCL is held low for the first half of every bit slot; START keeps it
    // released so the SDA fall in its second half forms the start condition.
    assign w_scl_oe    = (r_state != S_IDLE) && (r_state != S_START) && !r_q[1];

    // Clock stretching: while we release SCL but the line still reads low,
    // the slave is holding it, so the quarter timer freezes.
    assign w_stretch   = r_q[1] && !w_scl_oe && !scl_in;
    assign w_adv       = (r_state != S_IDLE) && !w_stretch;
    assign w_q_end     = w_adv && (r_cnt == LP_CNT_MAX);
    assign w_slot_end  = w_q_end && (r_q == 2'd3);
    assign w_sample    = w_q_end && (r_q == 2'd2);
    assign w_accept    = (r_state == S_IDLE) && start;
    assign w_byte_last = (r_bit == 3'd7);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch
        // can leave it unassigned and infer a latch.
        w_tx_bit = 1'b1;
        case (r_state)
            S_ADDR:  w_tx_bit = r_abyte[3'd7 - r_bit];
            S_WRITE: w_tx_bit = r_wdata[3'd7 - r_bit];
            default: w_tx_bit = 1'b1;
        endcase
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: registers use non-blocking assignment so every flop
            // samples the values present before the clock edge.
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_START;
            S_START: if (w_slot_end) w_state_next = S_ADDR;
            S_ADDR:  if (w_slot_end && w_byte_last) w_state_next = S_AACK;
            S_AACK: begin
                if (w_slot_end) begin
                    if (r_ack_err)       w_state_next = S_STOP;
                    else if (r_abyte[0]) w_state_next = S_READ;
                    else                 w_state_next = S_WRITE;
                end
            end
            S_WRITE: if (w_slot_end && w_byte_last) w_state_next = S_WACK;
            S_WACK:  if (w_slot_end) w_state_next = S_STOP;
            S_READ:  if (w_slot_end && w_byte_last) w_state_next = S_RNACK;
            S_RNACK: if (w_slot_end) w_state_next = S_STOP;
            S_STOP:  if (w_slot_end) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ---------------- SDA drive ----------------
    // SDA is registered and only updated on quarter boundaries. Data slots
    // switch at the q0->q1 boundary (mid SCL-low). START drops SDA while SCL
    // is high; STOP pulls SDA low from slot entry and releases it while SCL
    // is high.
    always_comb begin
        w_sda_oe_next = r_sda_oe;
        case (r_state)
            S_IDLE:  w_sda_oe_next = 1'b0;
            S_START: if (w_q_end && r_q == 2'd1) w_sda_oe_next = 1'b1;
            S_ADDR, S_WRITE:
                if (w_q_end && r_q == 2'd0) w_sda_oe_next = !w_tx_bit;
            S_AACK, S_WACK, S_READ, S_RNACK:
                if (w_q_end && r_q == 2'd0) w_sda_oe_next = 1'b0;
            S_STOP:  if (w_q_end && r_q == 2'd2) w_sda_oe_next = 1'b0;
            default: w_sda_oe_next = 1'b0;
        endcase
        if (w_slot_end && w_state_next == S_STOP) begin
            w_sda_oe_next = 1'b1;
        end
    end

    // ---------------- Datapath / timing ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_q       <= 2'd0;
            r_bit     <= 3'd0;
            r_abyte   <= 8'h00;
            r_wdata   <= 8'h00;
            r_rdata   <= 8'h00;
            r_ack_err <= 1'b0;
            r_sda_oe  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done   <= (r_state == S_STOP) && w_slot_end;
            r_sda_oe <= w_sda_oe_next;

            if (w_accept) begin
                r_abyte   <= {addr, rw};
                r_wdata   <= wdata;
                r_ack_err <= 1'b0;
                r_cnt     <= '0;
                r_q       <= 2'd0;
                r_bit     <= 3'd0;
            end else begin
                if (w_adv) begin
                    if (r_cnt == LP_CNT_MAX) begin
                        r_cnt <= '0;
                        r_q   <= r_q + 2'd1;
                    end else begin
                        r_cnt <= r_cnt + CBITS'(1);
                    end
                end

                // Bit index wraps 7->0 at the end of each byte phase.
                if (w_slot_end && (r_state == S_ADDR || r_state == S_WRITE ||
                                   r_state == S_READ)) begin
                    r_bit <= r_bit + 3'd1;
                end

                if (w_sample) begin
                    case (r_state)
                        S_AACK, S_WACK: if (sda_in) r_ack_err <= 1'b1;
                        S_READ:         r_rdata <= {r_rdata[6:0], sda_in};
                        default:        ;
                    endcase
                end
            end
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign done    = r_done;
    assign ack_err = r_ack_err;
    assign rdata   = r_rdata;
    assign scl_oe  = w_scl_oe;
    assign sda_oe  = r_sda_oe;

endmodule

// File: tb/tb_i2c_byte_sequencer.sv
// ---------------------------------------------------------------------------
// tb_i2c_byte_sequencer
//
// Directed bench for i2c_byte_sequencer at DIVIDER=4 (16 clk per bit slot).
// A small slave model drives the wired-AND pad levels: it ACKs or NACKs on
// request, returns a read byte, and can hold SCL low to stretch a slot.
// The master's SDA drive is recorded once per slot (in q2, SCL high) and
// compared with hand-derived 20-slot patterns (bit k = slot k, slot 0 =
// START), where a 1 means the master pulls SDA low.
// ---------------------------------------------------------------------------
module tb_i2c_byte_sequencer;

    localparam int D    = 4;
    localparam int SLOT = 4 * D;

    logic       clk;
    logic       rst;
    logic       start;
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic [7:0] rdata;
    logic       scl_oe;
    logic       sda_oe;
    logic       scl_in;
    logic       sda_in;

    logic       slave_pull;
    logic       scl_hold;

    int         n_chk;
    int         n_pass;

    // Open-drain pads with the slave sharing each line.
    assign scl_in = !scl_oe && !scl_hold;
    assign sda_in = !sda_oe && !slave_pull;

    i2c_byte_sequencer #(.DIVIDER(D), .CBITS(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .addr    (addr),
        .rw      (rw),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .ack_err (ack_err),
        .rdata   (rdata),
        .scl_oe  (scl_oe),
        .sda_oe  (sda_oe),
        .scl_in  (scl_in),
        .sda_in  (sda_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Issue one request and follow it cycle by cycle. c counts cycles after
    // the accept edge (c=1 is the first START cycle). The request fields are
    // scrambled right after accept to prove they were captured. A second
    // start can be injected at cycle inj_c; st_slot/st_len hold SCL low at
    // the start of q2 of that slot.
    task automatic run_txn(
        input  logic [6:0]  a,
        input  logic        r,
        input  logic [7:0]  w,
        input  logic        addr_ack,
        input  logic        data_ack,
        input  logic [7:0]  rbyte,
        input  int          st_slot,
        input  int          st_len,
        input  int          inj_c,
        output logic [19:0] sda_seen,
        output int          done_c,
        output int          n_done,
        output int          scl_err,
        output logic        busy_first,
        output logic        busy_at_done
    );
        int c;
        int s0;
        int eff;
        int slot;
        int pos;
        logic exp_scl;

        @(negedge clk);
        start = 1'b1;
        addr  = a;
        rw    = r;
        wdata = w;
        @(negedge clk);
        start        = 1'b0;
        addr         = ~a;
        rw           = ~r;
        wdata        = ~w;
        c            = 1;
        sda_seen     = '0;
        done_c       = 0;
        n_done       = 0;
        scl_err      = 0;
        busy_first   = busy;
        busy_at_done = 1'b1;
        s0 = (st_slot >= 0) ? (1 + SLOT * st_slot + 2 * D) : 1000000;

        while (c < 700 && !(done_c != 0 && c > done_c + 4)) begin
            if (c < s0)               eff = c - 1;
            else if (c < s0 + st_len) eff = s0 - 1;
            else                      eff = c - 1 - st_len;
            slot = eff / SLOT;
            pos  = eff % SLOT;

            scl_hold   = (c >= s0) && (c < s0 + st_len);
            slave_pull = 1'b0;
            if (slot == 9 && addr_ack)             slave_pull = 1'b1;
            if (!r && slot == 18 && data_ack)      slave_pull = 1'b1;
            if (r && slot >= 10 && slot <= 17)     slave_pull = !rbyte[17 - slot];
            start = (c == inj_c);

            if (done) begin
                n_done++;
                if (done_c == 0) begin
                    done_c       = c;
                    busy_at_done = busy;
                end
            end
            if (done_c == 0 && slot < 20) begin
                if (pos == 9) sda_seen[slot] = sda_oe;
                exp_scl = (slot != 0) && (pos < 2 * D);
                if (scl_oe !== exp_scl) scl_err++;
            end
            @(negedge clk);
            c++;
        end
        start      = 1'b0;
        slave_pull = 1'b0;
        scl_hold   = 1'b0;
    endtask

    logic [19:0] seen;
    int          dc;
    int          nd;
    int          se;
    logic        bf;
    logic        bd;
    int          cnt_done;

    initial begin
        n_chk      = 0;
        n_pass     = 0;
        rst        = 1'b1;
        start      = 1'b0;
        addr       = 7'h00;
        rw         = 1'b0;
        wdata      = 8'h00;
        slave_pull = 1'b0;
        scl_hold   = 1'b0;

        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_done",    32'(done),    32'd0);
        check("rst_ack_err", 32'(ack_err), 32'd0);
        check("rst_rdata",   32'(rdata),   32'd0);
        check("rst_scl_oe",  32'(scl_oe),  32'd0);
        check("rst_sda_oe",  32'(sda_oe),  32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Write 0x50 <- 0x3C, slave ACKs both bytes.
        run_txn(7'h50, 1'b0, 8'h3C, 1'b1, 1'b1, 8'h00, -1, 0, 0,
                seen, dc, nd, se, bf, bd);
        check("wr_busy_start", 32'(bf),      32'd1);
        check("wr_sda",        32'(seen),    32'(20'b1_0_11000011_0_11111010_1));
        check("wr_done_lat",   32'(dc),      32'd321);
        check("wr_busy_done",  32'(bd),      32'd0);
        check("wr_done_once",  32'(nd),      32'd1);
        check("wr_scl",        32'(se),      32'd0);
        check("wr_ack_err",    32'(ack_err), 32'd0);

        // Address 0x21 NACKed: STOP straight after AACK.
        run_txn(7'h21, 1'b0, 8'h99, 1'b0, 1'b1, 8'h00, -1, 0, 0,
                seen, dc, nd, se, bf, bd);
        check("nack_sda",      32'(seen),    32'(20'b000000000_1_0_10111101_1));
        check("nack_done_lat", 32'(dc),      32'd177);
        check("nack_ack_err",  32'(ack_err), 32'd1);
        check("nack_scl",      32'(se),      32'd0);

        // Read from 0x48, slave returns 0xA5; master NACKs in slot 18.
        run_txn(7'h48, 1'b1, 8'h00, 1'b1, 1'b1, 8'hA5, -1, 0, 0,
                seen, dc, nd, se, bf, bd);
        check("rd_sda",        32'(seen),    32'(20'b1_000000000_0_01110110_1));
        check("rd_rdata",      32'(rdata),   32'hA5);
        check("rd_done_lat",   32'(dc),      32'd321);
        check("rd_ack_err",    32'(ack_err), 32'd0);

        // Write data NACKed: full-length transfer, error flagged.
        run_txn(7'h50, 1'b0, 8'h3C, 1'b1, 1'b0, 8'h00, -1, 0, 0,
                seen, dc, nd, se, bf, bd);
        check("wnack_done_lat", 32'(dc),      32'd321);
        check("wnack_ack_err",  32'(ack_err), 32'd1);

        // Slave stretches the 3rd address bit by 10 cycles.
        run_txn(7'h50, 1'b0, 8'h3C, 1'b1, 1'b1, 8'h00, 3, 10, 0,
                seen, dc, nd, se, bf, bd);
        check("str_sda",       32'(seen),    32'(20'b1_0_11000011_0_11111010_1));
        check("str_done_lat",  32'(dc),      32'd331);
        check("str_scl",       32'(se),      32'd0);
        check("str_ack_err",   32'(ack_err), 32'd0);

        // Second start at cycle 100 of a busy transfer must be ignored.
        run_txn(7'h50, 1'b0, 8'h3C, 1'b1, 1'b1, 8'h00, -1, 0, 100,
                seen, dc, nd, se, bf, bd);
        check("inj_sda",       32'(seen),    32'(20'b1_0_11000011_0_11111010_1));
        check("inj_done_lat",  32'(dc),      32'd321);
        check("inj_done_once", 32'(nd),      32'd1);

        // Asynchronous reset at cycle 40 (ADDR slot 2, q1).
        @(negedge clk);
        start = 1'b1;
        addr  = 7'h50;
        rw    = 1'b0;
        wdata = 8'h3C;
        @(negedge clk);
        start = 1'b0;
        repeat (39) @(negedge clk);
        check("prerst_scl_oe", 32'(scl_oe), 32'd1);
        check("prerst_sda_oe", 32'(sda_oe), 32'd1);
        rst = 1'b0;
        #1;
        check("arst_scl_oe",   32'(scl_oe), 32'd0);
        check("arst_sda_oe",   32'(sda_oe), 32'd0);
        check("arst_busy",     32'(busy),   32'd0);
        cnt_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) cnt_done++;
        end
        rst = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done) cnt_done++;
        end
        check("arst_no_done",  32'(cnt_done), 32'd0);
        check("arst_idle",     32'(busy),     32'd0);

        run_txn(7'h50, 1'b0, 8'h3C, 1'b1, 1'b1, 8'h00, -1, 0, 0,
                seen, dc, nd, se, bf, bd);
        check("post_sda",      32'(seen),    32'(20'b1_0_11000011_0_11111010_1));
        check("post_done_lat", 32'(dc),      32'd321);
        check("post_ack_err",  32'(ack_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
